// File: rtl/adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_arbiter_pkg
//   Shared types and helpers for the adder arbiter slice.
//   - state_e    : controller states (IDLE -> EXEC -> RESP -> IDLE)
//   - id_width   : requester ID width, at least 1 bit even for a single client
//   - next_ptr   : round-robin pointer advance with wrap to 0
// -----------------------------------------------------------------------------
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Pointer moves to the slot just after the winner; NUM_REQ=1 stays at 0.
  function automatic int next_ptr(input int ptr, input int num_req);
    return (ptr >= num_req - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// -----------------------------------------------------------------------------
// adder_arbiter_if
//   Request/response bundle between ALU-lite clients and the adder arbiter.
//   Signal names keep the arbiter's point of view (i_* driven by clients,
//   o_* driven by the arbiter).
//   Request side : i_req_valid, i_req_a, i_req_b, i_req_carry_in, o_req_ready
//   Response side: o_resp_valid, i_resp_ready, o_resp_id, o_resp_s,
//                  o_resp_carry_out, o_resp_overflow (only with
//                  ADDER_ARBITER_OVERFLOW_EN defined)
//   Modports: master = client side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int N       = 64,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0][N-1:0] i_req_a;
  logic [NUM_REQ-1:0][N-1:0] i_req_b;
  logic [NUM_REQ-1:0]        i_req_carry_in;
  logic [NUM_REQ-1:0]        o_req_ready;

  logic                      o_resp_valid;
  logic                      i_resp_ready;
  logic [ID_W-1:0]           o_resp_id;
  logic [N-1:0]              o_resp_s;
  logic                      o_resp_carry_out;
`ifdef ADDER_ARBITER_OVERFLOW_EN
  logic                      o_resp_overflow;

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_carry_in, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_id, o_resp_s, o_resp_carry_out,
           o_resp_overflow
  );

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_carry_in, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_id, o_resp_s, o_resp_carry_out,
           o_resp_overflow
  );
`else
  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_carry_in, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_id, o_resp_s, o_resp_carry_out
  );

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_carry_in, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_id, o_resp_s, o_resp_carry_out
  );
`endif

endinterface

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
//   Team N-bit adder, generate/propagate formulation. Purely combinational.
//   i_a, i_b      : operands (N bits)
//   i_carry_in    : carry into bit 0
//   o_s           : sum modulo 2^N
//   o_carry_out   : carry out of bit N-1
// -----------------------------------------------------------------------------
module adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry_in,
  output logic [N-1:0] o_s,
  output logic         o_carry_out
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;

  assign gen  = i_a & i_b;
  assign prop = i_a ^ i_b;

  always_comb begin : carry_chain
    logic c;
    // NOTE: every output of a combinational block gets a value before any
    // conditional or loop touches it, so no path leaves it holding state.
    o_s = '0;
    c   = i_carry_in;
    for (int i = 0; i < N; i++) begin
      o_s[i] = prop[i] ^ c;
      c      = gen[i] | (prop[i] & c);
    end
    o_carry_out = c;
  end

endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Round-robin winner selection, purely combinational.
//   i_valid : request vector
//   i_ptr   : index with highest priority this round (< NUM_REQ)
//   o_grant : one-hot winner, all zero when nothing is valid
//   o_idx   : binary index of the winner (0 when nothing is valid)
//   The scan starts at i_ptr and wraps modulo NUM_REQ.
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  always_comb begin : scan
    logic found;
    int   j;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && i_valid[j]) begin
        found      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Shares one `adder` between NUM_REQ requesters. A round-robin picker grants
//   one request in IDLE, operands are registered, EXEC drives them through the
//   adder and registers the result, RESP holds it on a valid/ready channel.
//   Minimum occupancy is three cycles per operation; no overlap.
//
//   Ports:
//     i_clk : clock, all state on the rising edge
//     i_rst : synchronous, active-high reset (also masks ready/valid outputs)
//     bus   : adder_arbiter_if.slave carrying the request and response channels
//
//   Build option: ADDER_ARBITER_OVERFLOW_EN adds bus.o_resp_overflow, the
//   two's-complement overflow of the stored operation.
// -----------------------------------------------------------------------------
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N       = 64,
  parameter int NUM_REQ = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  adder_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_REQ);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q,   ptr_d;
  logic [N-1:0]        a_q,     a_d;
  logic [N-1:0]        b_q,     b_d;
  logic                cin_q,   cin_d;
  logic [ID_W-1:0]     id_q,    id_d;
  logic [N-1:0]        s_q,     s_d;
  logic                cout_q,  cout_d;
`ifdef ADDER_ARBITER_OVERFLOW_EN
  logic                ovf_q,   ovf_d;
`endif

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     win_idx;
  logic [N-1:0]        add_s;
  logic                add_cout;
  logic                req_fire;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_valid (bus.i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant),
    .o_idx   (win_idx)
  );

  // Adder sees only the operand registers, so late operand changes by the
  // client cannot leak into the result.
  adder #(
    .N (N)
  ) u_adder (
    .i_a         (a_q),
    .i_b         (b_q),
    .i_carry_in  (cin_q),
    .o_s         (add_s),
    .o_carry_out (add_cout)
  );

  assign bus.o_req_ready = (state_q == IDLE && !i_rst) ? grant : '0;
  assign req_fire        = |(bus.i_req_valid & bus.o_req_ready);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    id_d    = id_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef ADDER_ARBITER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          a_d     = bus.i_req_a[win_idx];
          b_d     = bus.i_req_b[win_idx];
          cin_d   = bus.i_req_carry_in[win_idx];
          id_d    = win_idx;
          ptr_d   = ID_W'(next_ptr(int'(win_idx), NUM_REQ));
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d     = add_s;
        cout_d  = add_cout;
`ifdef ADDER_ARBITER_OVERFLOW_EN
        ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_s[N-1] != a_q[N-1]);
`endif
        state_d = RESP;
      end
      RESP: begin
        if (bus.i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers take non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_ARBITER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef ADDER_ARBITER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.o_resp_valid     = (state_q == RESP) && !i_rst;
  assign bus.o_resp_id        = id_q;
  assign bus.o_resp_s         = s_q;
  assign bus.o_resp_carry_out = cout_q;
`ifdef ADDER_ARBITER_OVERFLOW_EN
  assign bus.o_resp_overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Directed bench for adder_arbiter (N=64, NUM_REQ=4). Inputs change 2 time
//   units after a rising edge; outputs are sampled 1 unit later, clear of the
//   edge. Expected values are hand-computed constants. With
//   ADDER_ARBITER_OVERFLOW_EN defined the overflow output is checked too.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int N       = 64;
  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adder_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

  adder_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [63:0] a, input logic [63:0] b,
                         input logic cin);
    bus.i_req_a[idx]        = a;
    bus.i_req_b[idx]        = b;
    bus.i_req_carry_in[idx] = cin;
  endtask

  initial begin
    bus.i_req_valid    = '0;
    bus.i_req_a        = '0;
    bus.i_req_b        = '0;
    bus.i_req_carry_in = '0;
    bus.i_resp_ready   = 1'b1;

    // ---- reset state ----
    step();
    step();
    set_req(0, 64'h12345678, 64'h87654321, 1'b0);
    bus.i_req_valid = 4'b0001;
    #1;
    check("rst_ready_masked", 64'(bus.o_req_ready), 64'h0);
    check("rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
    check("rst_resp_s", bus.o_resp_s, 64'h0);
    check("rst_resp_id", 64'(bus.o_resp_id), 64'h0);
    check("rst_resp_cout", 64'(bus.o_resp_carry_out), 64'h0);

    // ---- single request ----
    rst = 1'b0;
    #1;
    check("single_ready", 64'(bus.o_req_ready), 64'h1);
    step();                                    // accepted -> EXEC
    bus.i_req_valid = 4'b0000;
    set_req(0, 64'hDEAD_BEEF, 64'hFFFF_0000, 1'b1); // must not affect result
    #1;
    check("single_exec_ready", 64'(bus.o_req_ready), 64'h0);
    check("single_exec_valid", 64'(bus.o_resp_valid), 64'h0);
    step();                                    // RESP
    check("single_resp_valid", 64'(bus.o_resp_valid), 64'h1);
    check("single_resp_id", 64'(bus.o_resp_id), 64'h0);
    check("single_resp_s", bus.o_resp_s, 64'h99999999);
    check("single_resp_cout", 64'(bus.o_resp_carry_out), 64'h0);
    step();                                    // handshake -> IDLE
    check("single_done_valid", 64'(bus.o_resp_valid), 64'h0);
    check("single_hold_s", bus.o_resp_s, 64'h99999999);

    // ---- simultaneous req1/req2 from reset ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(1, 64'h5, 64'h7, 1'b1);
    set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0);
    bus.i_req_valid = 4'b0110;
    #1;
    check("sim_grant1", 64'(bus.o_req_ready), 64'h2);
    step();
    bus.i_req_valid = 4'b0100;
    #1;
    check("sim_exec_ready", 64'(bus.o_req_ready), 64'h0);
    step();
    check("sim_resp1_id", 64'(bus.o_resp_id), 64'h1);
    check("sim_resp1_s", bus.o_resp_s, 64'hD);
    check("sim_resp1_cout", 64'(bus.o_resp_carry_out), 64'h0);
    check("sim_resp1_ready", 64'(bus.o_req_ready), 64'h0);
    step();
    check("sim_grant2", 64'(bus.o_req_ready), 64'h4);
    step();
    bus.i_req_valid = 4'b0000;
    step();
    check("sim_resp2_id", 64'(bus.o_resp_id), 64'h2);
    check("sim_resp2_s", bus.o_resp_s, 64'h1);
    check("sim_resp2_cout", 64'(bus.o_resp_carry_out), 64'h1);
    step();

    // ---- continuous, all four requesting ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    bus.i_req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      check($sformatf("cont%0d_grant", g), 64'(bus.o_req_ready), 64'(1 << (g % 4)));
      step();
      check($sformatf("cont%0d_exec_ready", g), 64'(bus.o_req_ready), 64'h0);
      step();
      check($sformatf("cont%0d_valid", g), 64'(bus.o_resp_valid), 64'h1);
      check($sformatf("cont%0d_id", g), 64'(bus.o_resp_id), 64'(g % 4));
      check($sformatf("cont%0d_s", g), bus.o_resp_s, 64'hFFFF_FFFF_FFFF_FFFF);
      check($sformatf("cont%0d_cout", g), 64'(bus.o_resp_carry_out), 64'h1);
      check($sformatf("cont%0d_resp_ready", g), 64'(bus.o_req_ready), 64'h0);
      step();
    end

    // ---- backpressure (pointer now at 1) ----
    set_req(1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b1);
    bus.i_resp_ready = 1'b0;
    #1;
    check("bp_grant", 64'(bus.o_req_ready), 64'h2);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), 64'(bus.o_resp_valid), 64'h1);
      check($sformatf("bp%0d_id", i), 64'(bus.o_resp_id), 64'h1);
      check($sformatf("bp%0d_s", i), bus.o_resp_s, 64'h3333_3333_3333_3334);
      check($sformatf("bp%0d_ready", i), 64'(bus.o_req_ready), 64'h0);
      step();
    end
    check("bp_still_valid", 64'(bus.o_resp_valid), 64'h1);
    bus.i_resp_ready = 1'b1;
    step();
    check("bp_released_valid", 64'(bus.o_resp_valid), 64'h0);
    check("bp_next_grant", 64'(bus.o_req_ready), 64'h4);

    // ---- reset during EXEC ----
    set_req(3, 64'hAAAA, 64'h5555, 1'b0);
    bus.i_req_valid = 4'b1000;
    #1;
    check("rexec_grant3", 64'(bus.o_req_ready), 64'h8);
    step();                                    // req3 in EXEC
    rst = 1'b1;
    set_req(0, 64'h3, 64'h4, 1'b0);
    bus.i_req_valid = 4'b1001;
    #1;
    check("rexec_rst_ready", 64'(bus.o_req_ready), 64'h0);
    step();                                    // reset edge
    rst = 1'b0;
    #1;
    check("rexec_no_resp", 64'(bus.o_resp_valid), 64'h0);
    check("rexec_s_cleared", bus.o_resp_s, 64'h0);
    check("rexec_grant0", 64'(bus.o_req_ready), 64'h1);
    step();
    bus.i_req_valid = 4'b1000;
    step();
    check("rexec_resp_valid", 64'(bus.o_resp_valid), 64'h1);
    check("rexec_resp_id", 64'(bus.o_resp_id), 64'h0);
    check("rexec_resp_s", bus.o_resp_s, 64'h7);
    step();
    check("rexec_then_grant3", 64'(bus.o_req_ready), 64'h8);
    bus.i_req_valid = 4'b0000;

`ifdef ADDER_ARBITER_OVERFLOW_EN
    // ---- signed overflow flag ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ovf_rst", 64'(bus.o_resp_overflow), 64'h0);
    set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    bus.i_req_valid = 4'b0001;
    step();
    bus.i_req_valid = 4'b0000;
    step();
    check("ovf1_s", bus.o_resp_s, 64'h8000_0000_0000_0000);
    check("ovf1_cout", 64'(bus.o_resp_carry_out), 64'h0);
    check("ovf1_flag", 64'(bus.o_resp_overflow), 64'h1);
    step();
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    bus.i_req_valid = 4'b0001;
    #1;
    check("ovf2_wrap_grant", 64'(bus.o_req_ready), 64'h1);
    step();
    bus.i_req_valid = 4'b0000;
    step();
    check("ovf2_s", bus.o_resp_s, 64'h0);
    check("ovf2_cout", 64'(bus.o_resp_carry_out), 64'h1);
    check("ovf2_flag", 64'(bus.o_resp_overflow), 64'h0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
